// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message encoder.
package midi_pkg;

  // Event kinds as presented on the ev_type port.
  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_PROG     = 2'd2,
    EV_CTRL     = 2'd3
  } ev_type_t;

  // MIDI status nibbles (upper half of the status byte).
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_CTRL     = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;

  // Serialiser states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_ACK  = 2'd3
  } enc_state_t;

  // One queued event: 2 + 4 + 7 + 7 = 20 bits.
  typedef struct packed {
    ev_type_t    typ;
    logic [3:0]  chan;
    logic [6:0]  d1;
    logic [6:0]  d2;
  } midi_event_t;

  localparam int EVENT_W = $bits(midi_event_t);

  // Status nibble for an event type; note-off may be folded into note-on.
  function automatic logic [3:0] status_nibble(input ev_type_t t, input logic noteoff_zero);
    logic [3:0] nib;
    case (t)
      EV_NOTE_OFF: nib = noteoff_zero ? MIDI_NOTE_ON : MIDI_NOTE_OFF;
      EV_NOTE_ON:  nib = MIDI_NOTE_ON;
      EV_PROG:     nib = MIDI_PROG;
      default:     nib = MIDI_CTRL;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// Small synchronous FIFO holding pending MIDI events.
// Push is ignored when full, pop is ignored when empty; no bypass path.
module midi_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_encoder.sv
// MIDI message encoder: queues note/program/control events and serialises
// each as a 2- or 3-byte MIDI message onto a UART byte handshake.
//
// Handshakes:
//   event port : an event is taken on a rising edge where ev_valid && ev_ready;
//                ev_ready depends only on FIFO occupancy, never on ev_valid.
//   byte port  : a byte is issued only while tx_ready is high; tx_start pulses
//                for one cycle and tx_data holds until the next pulse. The byte
//                is considered taken once tx_ready is seen low afterwards.
module midi_msg_encoder
  import midi_pkg::*;
#(
  parameter int         DEPTH           = 4,
  parameter logic [6:0] NOTE_BASE       = 7'h32,
  parameter bit         RUNNING_STATUS  = 1'b1,
  parameter bit         NOTEOFF_AS_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_type,
  input  logic [3:0] ev_chan,
  input  logic [6:0] ev_d1,
  input  logic [6:0] ev_d2,
  input  logic [7:0] volume,
  input  logic       rs_clear,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [1:0] fsm_state
);

  enc_state_t  state;
  enc_state_t  next_state;

  midi_event_t wr_ev;
  midi_event_t head;
  logic [EVENT_W-1:0] head_raw;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  logic [7:0]  head_status;
  logic [7:0]  head_b1;
  logic [7:0]  head_b2;
  logic [1:0]  head_last;
  logic        head_is_note;
  logic        skip_status;

  logic [7:0]  msg_status;
  logic [7:0]  msg_b1;
  logic [7:0]  msg_b2;
  logic [1:0]  msg_last;
  logic [1:0]  idx;
  logic [7:0]  cur_byte;

  logic        issue;
  logic        rs_valid;
  logic [7:0]  last_status;

  // Bit 0 of volume is below MIDI velocity resolution.
  logic        unused_ok;
  assign unused_ok = volume[0];

  // Event capture: note events take velocity from the volume port.
  always_comb begin
    wr_ev      = '0;
    wr_ev.typ  = ev_type_t'(ev_type);
    wr_ev.chan = ev_chan;
    wr_ev.d1   = ev_d1;
    wr_ev.d2   = ev_type[1] ? ev_d2 : volume[7:1];
  end

  assign ev_ready = !fifo_full;
  assign push     = ev_valid && ev_ready;
  assign pop      = (state == ST_LOAD);

  midi_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ev),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = midi_event_t'(head_raw);

  // Byte formation for the event at the FIFO head.
  always_comb begin
    head_is_note = (head.typ == EV_NOTE_OFF) || (head.typ == EV_NOTE_ON);
    head_status  = {status_nibble(head.typ, NOTEOFF_AS_ZERO), head.chan};
    head_b1      = {1'b0, head_is_note ? (head.d1 + NOTE_BASE) : head.d1};
    head_b2      = {1'b0, head.d2};
    if (NOTEOFF_AS_ZERO && (head.typ == EV_NOTE_OFF)) begin
      head_b2 = 8'h00;
    end
    head_last    = (head.typ == EV_PROG) ? 2'd1 : 2'd2;
    skip_status  = RUNNING_STATUS && rs_valid && (head_status == last_status) && !rs_clear;
  end

  // Byte selected by the current index.
  always_comb begin
    case (idx)
      2'd0:    cur_byte = msg_status;
      2'd1:    cur_byte = msg_b1;
      default: cur_byte = msg_b2;
    endcase
  end

  // Serialiser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Serialiser next-state and byte-issue decode.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) next_state = ST_LOAD;
      ST_LOAD: next_state = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
          issue      = 1'b1;
          next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!tx_ready) begin
          next_state = (idx == msg_last) ? ST_IDLE : ST_SEND;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Message registers and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_status <= 8'h00;
      msg_b1     <= 8'h00;
      msg_b2     <= 8'h00;
      msg_last   <= 2'd0;
      idx        <= 2'd0;
    end else if (state == ST_LOAD) begin
      msg_status <= head_status;
      msg_b1     <= head_b1;
      msg_b2     <= head_b2;
      msg_last   <= head_last;
      idx        <= skip_status ? 2'd1 : 2'd0;
    end else if ((state == ST_ACK) && !tx_ready && (idx != msg_last)) begin
      idx <= idx + 2'd1;
    end
  end

  // Registered byte-port outputs; tx_data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= issue;
      if (issue) tx_data <= cur_byte;
    end
  end

  // Running-status memory; an issued status byte beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_valid    <= 1'b0;
      last_status <= 8'h00;
    end else if (issue && (idx == 2'd0)) begin
      rs_valid    <= 1'b1;
      last_status <= msg_status;
    end else if (rs_clear) begin
      rs_valid <= 1'b0;
    end
  end

  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_midi_msg_encoder.sv
// Bench for midi_msg_encoder: three instances with different options share
// the event inputs; ev_valid is routed to one selected instance at a time.
// Each instance drives its own 10-cycle-busy UART model; every byte started
// is logged as {instance, byte} and compared against an expected queue.
module tb_midi_msg_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       ev_valid = 1'b0;
  int         sel = 0;
  logic [1:0] ev_type = 2'd0;
  logic [3:0] ev_chan = 4'd0;
  logic [6:0] ev_d1 = 7'd0;
  logic [6:0] ev_d2 = 7'd0;
  logic [7:0] volume = 8'd0;
  logic       rs_clear = 1'b0;

  logic       ev_valid_i [3];
  logic       ev_ready_i [3];
  logic       tx_ready_i [3];
  logic       tx_start_i [3];
  logic [7:0] tx_data_i  [3];
  logic       busy_i     [3];
  logic [1:0] st_i       [3];
  logic       hold       [3] = '{1'b0, 1'b0, 1'b0};
  int         ucnt       [3] = '{0, 0, 0};
  logic       prev_start [3] = '{1'b0, 1'b0, 1'b0};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ev_valid_i[k] = ev_valid && (sel == k);
      tx_ready_i[k] = (ucnt[k] == 0) && !hold[k];
    end
  end

  // inst 0: plain encoding, no running status
  midi_msg_encoder #(.DEPTH(4), .NOTE_BASE(7'h32), .RUNNING_STATUS(1'b0), .NOTEOFF_AS_ZERO(1'b0)) dut_plain (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid_i[0]), .ev_ready(ev_ready_i[0]),
    .ev_type(ev_type), .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2), .volume(volume),
    .rs_clear(rs_clear), .tx_ready(tx_ready_i[0]), .tx_start(tx_start_i[0]),
    .tx_data(tx_data_i[0]), .busy(busy_i[0]), .fsm_state(st_i[0]));

  // inst 1: running status
  midi_msg_encoder #(.DEPTH(4), .NOTE_BASE(7'h32), .RUNNING_STATUS(1'b1), .NOTEOFF_AS_ZERO(1'b0)) dut_rs (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid_i[1]), .ev_ready(ev_ready_i[1]),
    .ev_type(ev_type), .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2), .volume(volume),
    .rs_clear(rs_clear), .tx_ready(tx_ready_i[1]), .tx_start(tx_start_i[1]),
    .tx_data(tx_data_i[1]), .busy(busy_i[1]), .fsm_state(st_i[1]));

  // inst 2: running status plus note-off as note-on velocity 0
  midi_msg_encoder #(.DEPTH(4), .NOTE_BASE(7'h32), .RUNNING_STATUS(1'b1), .NOTEOFF_AS_ZERO(1'b1)) dut_noz (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid_i[2]), .ev_ready(ev_ready_i[2]),
    .ev_type(ev_type), .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2), .volume(volume),
    .rs_clear(rs_clear), .tx_ready(tx_ready_i[2]), .tx_start(tx_start_i[2]),
    .tx_data(tx_data_i[2]), .busy(busy_i[2]), .fsm_state(st_i[2]));

  // ---------------- UART models and byte log ----------------
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];
  int pulse_err = 0;
  int overlap_err = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (tx_start_i[k]) begin
        if (ucnt[k] != 0) overlap_err++;
        ucnt[k] <= 10;
        log_q.push_back({2'(k), tx_data_i[k]});
      end else if (ucnt[k] != 0) begin
        ucnt[k] <= ucnt[k] - 1;
      end
      if (tx_start_i[k] && prev_start[k]) pulse_err++;
      prev_start[k] <= tx_start_i[k];
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input int k, input logic [7:0] b);
    exp_q.push_back({2'(k), b});
  endtask

  task automatic check_log(input string name);
    logic [9:0] e;
    logic [9:0] a;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (log_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: got no byte expected %0h", name, e);
      end else begin
        a = log_q.pop_front();
        check(name, a, e);
      end
    end
    check({name, "_extra"}, log_q.size(), 0);
    log_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_ev(input int k, input logic [1:0] t, input logic [3:0] c,
                         input logic [6:0] d1, input logic [6:0] d2, input logic [7:0] v);
    int n;
    @(negedge clk);
    sel = k; ev_type = t; ev_chan = c; ev_d1 = d1; ev_d2 = d2; volume = v;
    ev_valid = 1'b1;
    n = 0;
    while (!ev_ready_i[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ev_ready stayed %0b expected 1", ev_ready_i[k]);
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((busy_i[k] || !tx_ready_i[k]) && n < 800) begin
      @(negedge clk);
      n++;
    end
    if (n >= 800) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b tx_ready=%0b expected 0/1", busy_i[k], tx_ready_i[k]);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         k;
    logic [1:0] typ;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [7:0] vol;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [7:0] b;
    int n;

    vecs[0]  = '{0, 2'd1, 4'h2, 7'h05, 7'h00, 8'hC8, 3, 8'h92, 8'h37, 8'h64};
    vecs[1]  = '{0, 2'd2, 4'h0, 7'h15, 7'h00, 8'h00, 2, 8'hC0, 8'h15, 8'h00};
    vecs[2]  = '{0, 2'd3, 4'hF, 7'h07, 7'h7F, 8'h00, 3, 8'hBF, 8'h07, 8'h7F};
    vecs[3]  = '{0, 2'd0, 4'h3, 7'h50, 7'h00, 8'h41, 3, 8'h83, 8'h02, 8'h20};
    vecs[4]  = '{0, 2'd1, 4'h2, 7'h4E, 7'h00, 8'hFF, 3, 8'h92, 8'h00, 8'h7F};
    vecs[5]  = '{0, 2'd3, 4'h0, 7'h00, 7'h00, 8'hFF, 3, 8'hB0, 8'h00, 8'h00};
    vecs[6]  = '{1, 2'd1, 4'h1, 7'h10, 7'h00, 8'h80, 3, 8'h91, 8'h42, 8'h40};
    vecs[7]  = '{1, 2'd1, 4'h1, 7'h11, 7'h00, 8'h82, 2, 8'h43, 8'h41, 8'h00};
    vecs[8]  = '{1, 2'd2, 4'h1, 7'h05, 7'h00, 8'h00, 2, 8'hC1, 8'h05, 8'h00};
    vecs[9]  = '{1, 2'd2, 4'h1, 7'h06, 7'h00, 8'h00, 1, 8'h06, 8'h00, 8'h00};
    vecs[10] = '{1, 2'd1, 4'h1, 7'h10, 7'h00, 8'h80, 3, 8'h91, 8'h42, 8'h40};
    vecs[11] = '{2, 2'd1, 4'h4, 7'h20, 7'h00, 8'h64, 3, 8'h94, 8'h52, 8'h32};
    vecs[12] = '{2, 2'd0, 4'h4, 7'h20, 7'h00, 8'h64, 2, 8'h52, 8'h00, 8'h00};
    vecs[13] = '{2, 2'd0, 4'h5, 7'h00, 7'h00, 8'hFE, 3, 8'h95, 8'h32, 8'h00};

    // reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_tx_start%0d", k), tx_start_i[k], 1'b0);
      check($sformatf("rst_tx_data%0d", k), tx_data_i[k], 8'h00);
      check($sformatf("rst_ev_ready%0d", k), ev_ready_i[k], 1'b1);
      check($sformatf("rst_busy%0d", k), busy_i[k], 1'b0);
      check($sformatf("rst_state%0d", k), st_i[k], 2'd0);
    end
    rst_n = 1'b1;

    // table-driven messages
    for (int i = 0; i < 14; i++) begin
      send_ev(vecs[i].k, vecs[i].typ, vecs[i].chan, vecs[i].d1, vecs[i].d2, vecs[i].vol);
      for (int j = 0; j < vecs[i].n; j++) begin
        b = (j == 0) ? vecs[i].b0 : ((j == 1) ? vecs[i].b1 : vecs[i].b2);
        expect_byte(vecs[i].k, b);
      end
      wait_idle(vecs[i].k);
      check_log($sformatf("vec%0d", i));
    end

    // latency: accept at edge N, tx_start after edge N+3
    @(negedge clk);
    sel = 0; ev_type = 2'd2; ev_chan = 4'h6; ev_d1 = 7'h01; ev_d2 = 7'h00; volume = 8'h00;
    ev_valid = 1'b1;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    @(posedge clk); #1 check("lat_n1", tx_start_i[0], 1'b0);
    @(posedge clk); #1 check("lat_n2", tx_start_i[0], 1'b0);
    @(posedge clk); #1 check("lat_n3", tx_start_i[0], 1'b1);
    check("lat_data", tx_data_i[0], 8'hC6);
    expect_byte(0, 8'hC6);
    expect_byte(0, 8'h01);
    wait_idle(0);
    check_log("latency");

    // running status kept, then cleared, then back-to-back queued events
    send_ev(1, 2'd1, 4'h1, 7'h00, 7'h00, 8'h02);
    expect_byte(1, 8'h32); expect_byte(1, 8'h01);
    wait_idle(1);
    check_log("rs_keep");
    @(negedge clk) rs_clear = 1'b1;
    @(negedge clk) rs_clear = 1'b0;
    send_ev(1, 2'd1, 4'h1, 7'h01, 7'h00, 8'h04);
    expect_byte(1, 8'h91); expect_byte(1, 8'h33); expect_byte(1, 8'h02);
    wait_idle(1);
    check_log("rs_clear");
    send_ev(1, 2'd1, 4'h1, 7'h02, 7'h00, 8'h06);
    send_ev(1, 2'd1, 4'h1, 7'h03, 7'h00, 8'h08);
    expect_byte(1, 8'h34); expect_byte(1, 8'h03);
    expect_byte(1, 8'h35); expect_byte(1, 8'h04);
    wait_idle(1);
    check_log("rs_b2b");

    // FIFO full: one event parked in the serialiser, then four fill the FIFO
    hold[0] = 1'b1;
    send_ev(0, 2'd2, 4'h0, 7'h00, 7'h00, 8'h00);
    repeat (4) @(negedge clk);
    check("fifo_busy_held", busy_i[0], 1'b1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      sel = 0; ev_type = 2'd2; ev_chan = 4'(j); ev_d1 = 7'(j); ev_d2 = 7'h00; volume = 8'h00;
      ev_valid = 1'b1;
      acc = ev_ready_i[0];
      check($sformatf("fifo_accept%0d", j), acc, (j <= 4) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1 ev_valid = 1'b0;
    end
    @(negedge clk);
    check("fifo_full_ready", ev_ready_i[0], 1'b0);
    for (int j = 0; j <= 4; j++) begin
      expect_byte(0, {4'hC, 4'(j)});
      expect_byte(0, {1'b0, 7'(j)});
    end
    hold[0] = 1'b0;
    wait_idle(0);
    check("fifo_busy_done", busy_i[0], 1'b0);
    check("fifo_ready_done", ev_ready_i[0], 1'b1);
    check_log("fifo_order");

    // reset after the first byte of a 3-byte message
    send_ev(0, 2'd1, 4'h7, 7'h00, 7'h00, 8'h10);
    n = 0;
    while (!tx_start_i[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_started", tx_start_i[0], 1'b1);
    expect_byte(0, 8'h97);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_start", tx_start_i[0], 1'b0);
    check("rst_mid_tx_data", tx_data_i[0], 8'h00);
    check("rst_mid_ev_ready", ev_ready_i[0], 1'b1);
    check("rst_mid_busy", busy_i[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_quiet_busy", busy_i[0], 1'b0);
    check_log("rst_abort");
    send_ev(1, 2'd1, 4'h1, 7'h05, 7'h00, 8'h0A);
    expect_byte(1, 8'h91); expect_byte(1, 8'h37); expect_byte(1, 8'h05);
    wait_idle(1);
    check_log("rst_rs");

    check("pulse_width", pulse_err, 0);
    check("start_overlap", overlap_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_msg_encoder.md
# midi_msg_encoder

Parametrised MIDI message encoder between the note/event logic and the UART transmitter. Note-off, note-on, program-change and control-change events are accepted on a valid/ready port and queued in a small event FIFO. Each event is serialised as a 2- or 3-byte MIDI message over the transmitter's `tx_ready`/`tx_start` byte handshake. Adds per-event channel, queuing, optional running-status compression and optional note-off-as-note-on-zero encoding.

## Interface
- `DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `NOTE_BASE`, 7'h32: offset added to the note number of note events, modulo 128.
- `RUNNING_STATUS`, 1: 1 = omit the status byte when it equals the last status sent.
- `NOTEOFF_AS_ZERO`, 0: 1 = note-off is sent as status 0x9n with velocity 0.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  `!fifo_full`; event accepted on `ev_valid && ev_ready`.
- `ev_type`  in  2  0 note-off, 1 note-on, 2 program change, 3 control change.
- `ev_chan`  in  4  MIDI channel n.
- `ev_d1`  in  7  note index (types 0/1), program (2), controller (3).
- `ev_d2`  in  7  controller value (type 3); ignored for other types.
- `volume`  in  8  velocity source; `volume[7:1]` is captured at accept for types 0/1.
- `rs_clear`  in  1  invalidates the running-status memory.
- `tx_ready`  in  1  UART idle; low while a byte is shifting.
- `tx_start`  out  1  one-cycle byte-start pulse, registered.
- `tx_data`  out  8  byte to send; registered, stable from the `tx_start` pulse until the next pulse.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- **FIFO write.** Each accepted event is stored as {type, chan, d1, d2'}, 20 bits wide. For types 0/1, d2' = `volume[7:1]`; otherwise d2' = `ev_d2`.
- **Message bytes.**
  - Status byte = {nibble, chan}. Nibbles: type0 → 0x8, or 0x9 when `NOTEOFF_AS_ZERO`; type1 → 0x9; type2 → 0xC; type3 → 0xB.
  - Byte 1 = {0, d1}. For types 0/1, d1 is replaced by (d1 + `NOTE_BASE`) mod 128.
  - Byte 2 = {0, d2'}. When type0 and `NOTEOFF_AS_ZERO`, byte 2 = 0x00.
  - Type 2 sends no byte 2.
- **FSM states:** IDLE, LOAD, SEND, ACK.
  - IDLE: when the FIFO is non-empty, go to LOAD.
  - LOAD: pop the FIFO head into the message registers. Compute `skip_status` = `RUNNING_STATUS && rs_valid && status == last_status && !rs_clear`. Set byte index to 1 if `skip_status`, else 0. Go to SEND.
  - SEND: when `tx_ready` = 1, register `tx_start` = 1 and `tx_data` = byte[index], then go to ACK. Otherwise hold.
  - ACK: wait for `tx_ready` = 0.
    - If the last byte has been sent, go to IDLE.
    - Otherwise increment the index and go to SEND.
- **Running-status memory.** `last_status`/`rs_valid` update when a status byte is issued.
  - `rs_clear` clears `rs_valid` in any state.
  - If `rs_clear` and a status issue occur in the same cycle, the issue wins; `rs_valid` = 1.
- **FIFO boundaries.**
  - Full: `ev_ready` = 0 and the offered event is not taken, even if a pop occurs in the same cycle (no bypass).
  - Empty: no pop.
  - Simultaneous push and pop when neither full nor empty: both happen and the count is unchanged.
  - Pointers wrap modulo `DEPTH`.

## Timing
- **Reset values:** `tx_start` 0, `tx_data` 0x00, `ev_ready` 1, `busy` 0. FSM in IDLE, FIFO empty, `rs_valid` 0.
- **Reset mid-message:** the message is abandoned and no further `tx_start` is issued. A byte already in the UART completes on its own.
- **Latency:** with the FIFO empty, FSM in IDLE and `tx_ready` held high, an event accepted at edge N gives `tx_start` high after edge N+3 (N+1 IDLE→LOAD, N+2 LOAD→SEND, N+3 issue).
- **Byte spacing:** the next `tx_start` comes no earlier than 2 cycles after `tx_ready` falls (ACK→SEND, then issue).
- **Pulse width:** `tx_start` is never high in two consecutive cycles.

## Structure
- Package `midi_pkg` holds:
  - `ev_type_t` enum;
  - status nibble constants `MIDI_NOTE_OFF` = 4'h8, `MIDI_NOTE_ON` = 4'h9, `MIDI_CTRL` = 4'hB, `MIDI_PROG` = 4'hC;
  - `enc_state_t` FSM typedef;
  - the 20-bit event struct.
- Sub-module `midi_event_fifo`: synchronous FIFO parametrised by `DEPTH` and width, with full/empty outputs and async active-low reset.
- The serialiser FSM and running-status logic stay in the top module.

## Test plan
- **Note-on, ch 2:** `NOTE_BASE` = 0x32, `RUNNING_STATUS` = 0; type1, chan 2, d1 = 5, `volume` = 0xC8, `tx_ready` tied high through a 10-cycle-busy UART model → bytes 0x92, 0x37, 0x64.
- **Program change:** type2, chan 0, d1 = 0x15 → exactly 2 bytes, 0xC0 then 0x15.
- **Running status:** two note-ons on chan 1 back-to-back with `RUNNING_STATUS` = 1 → 0x91, n1, v1, n2, v2. Repeat with `rs_clear` pulsed between them → status byte resent.
- **Note-off as zero:** `NOTEOFF_AS_ZERO` = 1; note-on then note-off, same channel and note, with `RUNNING_STATUS` = 1 → second message is 2 bytes, {note, 0x00}.
- **FIFO boundaries:** `DEPTH` = 4; hold `tx_ready` low and offer 6 events → `ev_ready` drops after the 4th accept. Release `tx_ready` → the 4 events are sent in order, and `busy` falls after the last ACK.
- **Reset mid-message:** assert `rst_n` low after the first `tx_start` of a 3-byte message → `tx_start` stays 0, outputs at reset values. After release, a new event sends its full status byte (`rs_valid` cleared).
